// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-initiator split-capable bus arbiter.
//   arb_state_e            : arbiter FSM states
//   OWN_NONE/OWN_I1/OWN_I2 : encoding of the owner mux select
//   TIMEOUT_CYCLES_DEFAULT : default watchdog limit in cycles
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GNT1      = 2'd1,
    ST_GNT2      = 2'd2,
    ST_SPLIT_RET = 2'd3
  } arb_state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_I1   = 2'd1;
  localparam logic [1:0] OWN_I2   = 2'd2;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/bus_arbiter.sv
// Two-initiator bus arbiter with split-transaction return path and watchdog.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   init1_req, init2_req       : initiator requests (level)
//   init1_grant, init2_grant   : initiator grants
//   txn_done                   : current transaction completed (pulse)
//   split_ack                  : split target deferred the current read (pulse)
//   split_req                  : split target has deferred data ready (level)
//   split_done                 : deferred data delivered (pulse)
//   split_grant                : grant to split target
//   owner                      : bus mux select (0 none, 1 init1, 2 init2)
//   split_pending              : a deferred read is outstanding
//   timeout                    : one-cycle pulse on watchdog forced release
//   protocol_err               : sticky protocol violation flag
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       init1_req,
  input  logic       init2_req,
  output logic       init1_grant,
  output logic       init2_grant,
  input  logic       txn_done,
  input  logic       split_ack,
  input  logic       split_req,
  input  logic       split_done,
  output logic       split_grant,
  output logic [1:0] owner,
  output logic       split_pending,
  output logic       timeout,
  output logic       protocol_err
);

  // The watchdog fires on the last permitted cycle so that a grant is held
  // for exactly TIMEOUT_CYCLES cycles.
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);

  arb_state_e state_q, state_d;
  logic [1:0] split_owner_q, split_owner_d;
  logic       split_pending_q, split_pending_d;
  logic [1:0] last_q, last_d;
  logic [7:0] wdog_q, wdog_d;
  logic       timeout_q, timeout_d;
  logic       err_q, err_d;

  logic       req1_eff, req2_eff;
  logic       own_req;
  logic [1:0] own_id;
  logic       wdog_hit;

  always_comb begin
    state_d         = state_q;
    split_owner_d   = split_owner_q;
    split_pending_d = split_pending_q;
    last_d          = last_q;
    timeout_d       = 1'b0;
    err_d           = err_q;
    own_req         = 1'b0;
    own_id          = OWN_NONE;
    wdog_hit        = (wdog_q == WDOG_LAST);

    // The initiator waiting on a deferred read may not re-enter arbitration.
    req1_eff = init1_req && !(split_pending_q && (split_owner_q == OWN_I1));
    req2_eff = init2_req && !(split_pending_q && (split_owner_q == OWN_I2));

    if (split_req && !split_pending_q) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (split_ack || txn_done) begin
          err_d = 1'b1;
        end
        if (split_req && split_pending_q) begin
          state_d = ST_SPLIT_RET;
        end else if (req1_eff && (!req2_eff || (last_q == OWN_I2))) begin
          state_d = ST_GNT1;
          last_d  = OWN_I1;
        end else if (req2_eff) begin
          state_d = ST_GNT2;
          last_d  = OWN_I2;
        end
      end

      ST_GNT1, ST_GNT2: begin
        own_req = (state_q == ST_GNT1) ? init1_req : init2_req;
        own_id  = (state_q == ST_GNT1) ? OWN_I1 : OWN_I2;
        if (split_ack) begin
          state_d = ST_IDLE;
          if (split_pending_q) begin
            // Only one deferred read can be tracked; behave as completion.
            err_d = 1'b1;
          end else begin
            split_pending_d = 1'b1;
            split_owner_d   = own_id;
          end
        end else if (txn_done || !own_req) begin
          state_d = ST_IDLE;
        end else if (wdog_hit) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end

      ST_SPLIT_RET: begin
        if (split_ack || txn_done) begin
          err_d = 1'b1;
        end
        if (split_done) begin
          state_d         = ST_IDLE;
          split_pending_d = 1'b0;
          last_d          = split_owner_q;
        end else if (wdog_hit) begin
          state_d         = ST_IDLE;
          split_pending_d = 1'b0;
          timeout_d       = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Watchdog restarts on every state change and only runs while a grant is held.
    if ((state_d != state_q) || (state_q == ST_IDLE)) begin
      wdog_d = 8'd0;
    end else begin
      wdog_d = wdog_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      split_owner_q   <= OWN_NONE;
      split_pending_q <= 1'b0;
      last_q          <= OWN_I2;
      wdog_q          <= 8'd0;
      timeout_q       <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      split_owner_q   <= split_owner_d;
      split_pending_q <= split_pending_d;
      last_q          <= last_d;
      wdog_q          <= wdog_d;
      timeout_q       <= timeout_d;
      err_q           <= err_d;
    end
  end

  assign init1_grant   = (state_q == ST_GNT1);
  assign init2_grant   = (state_q == ST_GNT2);
  assign split_grant   = (state_q == ST_SPLIT_RET);
  assign split_pending = split_pending_q;
  assign timeout       = timeout_q;
  assign protocol_err  = err_q;

  always_comb begin
    case (state_q)
      ST_GNT1:      owner = OWN_I1;
      ST_GNT2:      owner = OWN_I2;
      ST_SPLIT_RET: owner = split_owner_q;
      default:      owner = OWN_NONE;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (watchdog limit set to 8).
// Observed vector: {init1_grant, init2_grant, split_grant, owner[1:0],
//                   split_pending, timeout, protocol_err}
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic       init1_req, init2_req;
  logic       init1_grant, init2_grant;
  logic       txn_done, split_ack, split_req, split_done;
  logic       split_grant;
  logic [1:0] owner;
  logic       split_pending, timeout, protocol_err;
  logic [7:0] obs;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .init1_req    (init1_req),
    .init2_req    (init2_req),
    .init1_grant  (init1_grant),
    .init2_grant  (init2_grant),
    .txn_done     (txn_done),
    .split_ack    (split_ack),
    .split_req    (split_req),
    .split_done   (split_done),
    .split_grant  (split_grant),
    .owner        (owner),
    .split_pending(split_pending),
    .timeout      (timeout),
    .protocol_err (protocol_err)
  );

  assign obs = {init1_grant, init2_grant, split_grant, owner, split_pending, timeout, protocol_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Leaves the bench #1 after a rising edge with reset released: cycle 0.
  task automatic do_reset();
    init1_req = 0; init2_req = 0; txn_done = 0;
    split_ack = 0; split_req = 0; split_done = 0;
    rst_n = 0;
    #1;
    chk("reset", 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    rst_n = 0;
    init1_req = 0; init2_req = 0; txn_done = 0;
    split_ack = 0; split_req = 0; split_done = 0;
    #2;

    // A: simultaneous requests, init1 first, init2 after turnaround
    do_reset();
    init1_req = 1; init2_req = 1;
    chk("A_c0_idle", 8'h00);
    tick(); chk("A_c1_g1", 8'h88);
    tick(); chk("A_c2_g1", 8'h88);
    tick(); chk("A_c3_g1", 8'h88); txn_done = 1;
    tick(); chk("A_c4_turn", 8'h00); txn_done = 0;
    tick(); chk("A_c5_g2_rr", 8'h50); init1_req = 0; txn_done = 1;
    tick(); chk("A_c6_rel", 8'h00); txn_done = 0; init2_req = 0;
    tick(); chk("A_c7_idle", 8'h00);

    // B: split_ack on init1, init2 served meanwhile, init1 masked
    do_reset();
    init1_req = 1; init2_req = 1;
    tick(); chk("B_c1_g1", 8'h88);
    tick(); tick();
    chk("B_c3_g1", 8'h88);
    tick(); chk("B_c4_g1", 8'h88); split_ack = 1;
    tick(); chk("B_c5_pend", 8'h04); split_ack = 0;
    tick(); chk("B_c6_g2", 8'h54);
    tick(); chk("B_c7_g2", 8'h54); txn_done = 1;
    tick(); chk("B_c8_idle", 8'h04); txn_done = 0; init2_req = 0;
    tick(); chk("B_c9_mask", 8'h04);
    tick(); chk("B_c10_mask", 8'h04);

    // C: split return beats init2, then init2 wins tie after return
    split_req = 1; init2_req = 1;
    tick(); chk("C_c11_sret", 8'h2C);
    tick(); chk("C_c12_sret", 8'h2C); split_done = 1; split_req = 0;
    tick(); chk("C_c13_turn", 8'h00); split_done = 0;
    tick(); chk("C_c14_g2", 8'h50); txn_done = 1;
    tick(); chk("C_c15_idle", 8'h00); txn_done = 0; init2_req = 0;
    tick(); chk("C_c16_g1", 8'h88); init1_req = 0;
    tick(); chk("C_c17_idle", 8'h00);

    // D: watchdog forced release after 8 cycles
    do_reset();
    init2_req = 1;
    for (int i = 1; i <= 8; i++) begin
      tick(); chk($sformatf("D_c%0d_g2", i), 8'h50);
    end
    tick(); chk("D_c9_timeout", 8'h02); init2_req = 0;
    tick(); chk("D_c10_once", 8'h00);
    tick(); chk("D_c11_idle", 8'h00);

    // E: split_req with nothing pending -> error, sticky, no grant
    do_reset();
    split_req = 1;
    tick(); chk("E_c1_err", 8'h01); split_req = 0;
    tick(); chk("E_c2_sticky", 8'h01); init1_req = 1;
    tick(); chk("E_c3_g1_err", 8'h89); init1_req = 0;
    tick(); chk("E_c4_sticky", 8'h01);

    // G: txn_done in IDLE -> error
    do_reset();
    txn_done = 1;
    tick(); chk("G_c1_err", 8'h01); txn_done = 0;
    tick(); chk("G_c2_sticky", 8'h01);

    // F: asynchronous reset during split return
    do_reset();
    init1_req = 1;
    tick(); chk("F_c1_g1", 8'h88); split_ack = 1;
    tick(); chk("F_c2_pend", 8'h04); split_ack = 0; split_req = 1;
    tick(); chk("F_c3_sret", 8'h2C);
    #2;
    rst_n = 0;
    #1;
    chk("F_async_rst", 8'h00);
    init1_req = 0; split_req = 0;
    @(posedge clk);
    #1;
    chk("F_in_rst", 8'h00);
    rst_n = 1;
    tick(); chk("F_after_rst", 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
